dff_pipe: RTL and testbench
===========================

Name: dff_pipe

Overview:
Parametrised elastic register pipeline. It is the multi-bit, multi-stage successor of the single-bit DFF. It moves WIDTH-bit words through DEPTH registered stages with a valid/ready handshake, bubble collapsing, a synchronous flush and an occupancy count. It sits between producer/consumer blocks in the verification sandbox designs, as a retiming or latency-matching element.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 4, number of register stages (>=1)
CNT_W, $clog2(DEPTH+1), width of occupancy count (derived; do not override)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous clear of all stage valids
in_valid  input  1  producer presents a word
in_data  input  WIDTH  producer word
in_ready  output  1  pipeline accepts the word this cycle
out_valid  output  1  last stage holds a word
out_data  output  WIDTH  last stage word
out_ready  input  1  consumer accepts the word this cycle
count  output  CNT_W  number of valid stages
empty  output  1  count == 0
full  output  1  count == DEPTH

Behaviour:
- One clock, clk. Reset is synchronous and active-high; all state changes on the rising edge of clk only.
- Reset (reset=1 at the edge): all stage valids=0 and all stage data=0. Gives out_valid=0, out_data=0, count=0, empty=1, full=0.
- Priority per edge: reset > flush > normal operation.
- Flush: clears all valids; data registers keep their value; count becomes 0 next cycle.
  - in_ready is forced 0 while flush=1, so no word is accepted in a flush cycle.
  - out_valid still reflects the current state that cycle. A consumer handshake in the flush cycle completes, and that word counts as delivered.
- Stage state: per stage i (0..DEPTH-1), valid[i] and data[i]. Stage 0 is nearest the input; stage DEPTH-1 drives out_*.
- Advance rule (combinational):
  - adv[DEPTH-1] = valid[DEPTH-1] & out_ready
  - adv[i] = valid[i] & (!valid[i+1] | adv[i+1])
  - A stage loads from upstream when it is empty or advancing.
- in_ready = (!valid[0] | adv[0]) & !flush. Accept = in_valid & in_ready.
- Bubbles collapse: a word moves forward whenever the next stage is empty or being vacated, even if downstream is stalled.
- Latency: a word accepted at edge N appears on out_valid/out_data after edge N+DEPTH-1, with no stall. Example: DEPTH=1 is visible the cycle after acceptance.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Order is preserved; no word is duplicated or dropped except by flush or reset.
- Simultaneous push and pop with the pipeline full: allowed. Full throughput with no bubble, because the advance chain is combinational end to end.
- count update:
  - +1 on accept without pop
  - -1 on pop (out_valid & out_ready) without accept
  - unchanged on both or neither
  - count equals popcount(valid) at all times.
- empty/full are registered-equivalent decodes of count.
- Data rule: out_data is meaningful only while out_valid=1. A stage's data register loads only when that stage loads a valid word.
- No protocol checking of the producer. in_data may change while in_valid=0.

Optional Feature:
DFF_PIPE_XSCRUB_EN
- Defined: each bit of in_data that is X or Z at accept time is stored as 0. The 4-state case-equality check applies per bit. Simulation-only semantics; synthesises to a plain wire.
- Not defined: in_data is stored unmodified and X/Z propagates to out_data.

Decomposition:
- Package dff_pipe_pkg holds:
  - function clog2_cnt(depth), returning the CNT_W computation
  - localparam defaults DFF_PIPE_WIDTH_DEF=8 and DFF_PIPE_DEPTH_DEF=4
  - typedef of the handshake struct {valid, data} for bench reuse.
- One natural sub-module: dff_pipe_stage. It holds one valid and data register, with load and clear inputs, and is instantiated DEPTH times by a generate loop.
- count/empty/full logic and the advance chain live in the top module.

Test Plan:
- Reset: WIDTH=8, DEPTH=4. Hold reset=1 for 2 cycles with in_valid=1, in_data=8'hA5 -> out_valid=0, out_data=0, count=0, empty=1, in_ready=1 after release.
- Streaming: push 8'h01..8'h08 back-to-back with out_ready=1 -> 8'h01 appears on out_data 3 cycles after its accept, then one word per cycle in order. count stays 4 at steady state.
- Backpressure/bubble collapse: push 8'h11, idle 2 cycles, push 8'h22, with out_ready=0 -> words pack into stages 3 and 2. Then push 8'h33 and 8'h44 -> full=1, count=4, in_ready=0. Release out_ready -> output order 11,22,33,44.
- Full simultaneous push/pop: full pipeline, in_valid=1, out_ready=1 for 6 cycles -> in_ready=1 every cycle, count stays 4, no gaps on out_valid.
- Flush mid-stream: count=3, assert flush with in_valid=1, in_data=8'hEE -> in_ready=0 that cycle; next cycle count=0, out_valid=0, and 8'hEE never appears on out_data.
- X-scrub: DFF_PIPE_XSCRUB_EN defined, push 8'b1x0z_1010 -> out_data=8'b1000_1010. Macro undefined -> out_data shows x/z in bits 6 and 4.

Source files
------------

// File: rtl/dff_pipe_pkg.sv
// Shared defaults, count-width helper and handshake word type for the dff_pipe elastic pipeline.
package dff_pipe_pkg;

    localparam int unsigned DFF_PIPE_WIDTH_DEF = 8;
    localparam int unsigned DFF_PIPE_DEPTH_DEF = 4;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int unsigned clog2_cnt(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic                          valid;
        logic [DFF_PIPE_WIDTH_DEF-1:0] data;
    } dff_pipe_hs_t;

endpackage

// File: rtl/dff_pipe_stage.sv
// One elastic pipeline stage: a valid flag plus a data word that only loads alongside a valid.
module dff_pipe_stage import dff_pipe_pkg::*; #(
    parameter int unsigned WIDTH = DFF_PIPE_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic             up_valid_i,
    input  logic [WIDTH-1:0] up_data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = up_valid_i;
            if (up_valid_i) begin
                data_d = up_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/dff_pipe.sv
// Elastic DEPTH-stage register pipeline with valid/ready handshake, bubble collapse, flush and
// occupancy count. Define DFF_PIPE_XSCRUB_EN to store X/Z input bits as 0 (simulation only).
module dff_pipe import dff_pipe_pkg::*; #(
    parameter int unsigned WIDTH = DFF_PIPE_WIDTH_DEF,
    parameter int unsigned DEPTH = DFF_PIPE_DEPTH_DEF,
    parameter int unsigned CNT_W = clog2_cnt(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] up_valid;
    logic [WIDTH-1:0] data    [DEPTH];
    logic [WIDTH-1:0] up_data [DEPTH];
    logic [WIDTH-1:0] in_data_s;
    logic             accept;
    logic             pop;
    logic [CNT_W-1:0] count_q, count_d;

`ifdef DFF_PIPE_XSCRUB_EN
    // Only a definite 1 survives; X and Z collapse to 0. Reduces to a wire in synthesis.
    always_comb begin
        in_data_s = '0;
        for (int b = 0; b < int'(WIDTH); b++) begin
            in_data_s[b] = (in_data[b] === 1'b1);
        end
    end
`else
    assign in_data_s = in_data;
`endif

    // Advance chain resolved end to end in one block so a full pipe can push and pop together.
    always_comb begin
        adv            = '0;
        adv[DEPTH-1]   = valid[DEPTH-1] & out_ready;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            adv[i] = valid[i] & (~valid[i+1] | adv[i+1]);
        end
    end

    assign load     = ~valid | adv;
    assign in_ready = (~valid[0] | adv[0]) & ~flush;
    assign accept   = in_valid & in_ready;
    assign pop      = valid[DEPTH-1] & out_ready;

    always_comb begin
        up_valid    = '0;
        up_valid[0] = accept;
        up_data[0]  = in_data_s;
        for (int i = 1; i < int'(DEPTH); i++) begin
            up_valid[i] = valid[i-1];
            up_data[i]  = data[i-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        dff_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .load_i     (load[g]),
            .clear_i    (flush),
            .up_valid_i (up_valid[g]),
            .up_data_i  (up_data[g]),
            .valid_o    (valid[g]),
            .data_o     (data[g])
        );
    end

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (accept && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !accept) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign out_valid = valid[DEPTH-1];
    assign out_data  = data[DEPTH-1];

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe: directed scenarios plus random traffic against a FIFO model.
module tb_dff_pipe;
    import dff_pipe_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = clog2_cnt(DEPTH);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;

    dff_pipe #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: words currently held by the pipeline, oldest first.
    logic [WIDTH-1:0] exp_q [$];

    logic             s_in_ready, s_out_valid, s_empty, s_full, s_flush, s_out_ready;
    logic [WIDTH-1:0] s_out_data, s_front;
    logic [CNT_W-1:0] s_count;
    int               s_size;

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic rdy,
                         input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        flush     = fl;
    endtask

    // Sample outputs mid-cycle, update the model with this cycle's handshakes, then clock.
    task automatic tick();
        @(negedge clk);
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_out_data  = out_data;
        s_count     = count;
        s_empty     = empty;
        s_full      = full;
        s_flush     = flush;
        s_out_ready = out_ready;
        s_size      = exp_q.size();
        s_front     = (s_size > 0) ? exp_q[0] : '0;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back(in_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (DEPTH + 1) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        n_vec++; if (s_out_valid !== 1'b0) begin n_err++;
            $display("FAIL reset out_valid: got %b want 0", s_out_valid); end
        n_vec++; if (s_out_data !== 8'h00) begin n_err++;
            $display("FAIL reset out_data: got %h want 00", s_out_data); end
        n_vec++; if (s_count !== '0) begin n_err++;
            $display("FAIL reset count: got %0d want 0", s_count); end
        n_vec++; if (s_empty !== 1'b1 || s_full !== 1'b0) begin n_err++;
            $display("FAIL reset empty/full: got %b/%b want 1/0", s_empty, s_full); end
        n_vec++; if (s_in_ready !== 1'b1) begin n_err++;
            $display("FAIL reset in_ready: got %b want 1", s_in_ready); end
    endtask

    task automatic test_streaming();
        for (int t = 0; t < 12; t++) begin
            drive(t < 8, 8'(t + 1), 1'b1, 1'b0);
            tick();
            n_vec++; if (s_out_valid !== (t >= 4)) begin n_err++;
                $display("FAIL stream out_valid t=%0d: got %b want %b", t, s_out_valid, t >= 4);
            end
            if (t >= 4) begin
                n_vec++; if (s_out_data !== 8'(t - 3)) begin n_err++;
                    $display("FAIL stream out_data t=%0d: got %h want %h", t, s_out_data,
                             8'(t - 3)); end
            end
            if (t >= 4 && t <= 8) begin
                n_vec++; if (s_count !== CNT_W'(4)) begin n_err++;
                    $display("FAIL stream count t=%0d: got %0d want 4", t, s_count); end
            end
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        n_vec++; if (s_empty !== 1'b1) begin n_err++;
            $display("FAIL stream drained empty: got %b want 1", s_empty); end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] want [4];
        want = '{8'h11, 8'h22, 8'h33, 8'h44};
        drive(1'b1, 8'h11, 1'b0, 1'b0); tick();
        drive(1'b0, '0, 1'b0, 1'b0);    tick(); tick();
        drive(1'b1, 8'h22, 1'b0, 1'b0); tick();
        drive(1'b0, '0, 1'b0, 1'b0);    tick(); tick();
        drive(1'b1, 8'h33, 1'b0, 1'b0); tick();
        n_vec++; if (s_count !== CNT_W'(2) || s_out_valid !== 1'b1 || s_out_data !== 8'h11)
        begin n_err++;
            $display("FAIL bp packed: got count=%0d ov=%b od=%h want 2/1/11", s_count,
                     s_out_valid, s_out_data); end
        n_vec++; if (s_in_ready !== 1'b1) begin n_err++;
            $display("FAIL bp in_ready partial: got %b want 1", s_in_ready); end
        drive(1'b1, 8'h44, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h55, 1'b0, 1'b0); tick();
        n_vec++; if (s_full !== 1'b1 || s_count !== CNT_W'(4)) begin n_err++;
            $display("FAIL bp full: got full=%b count=%0d want 1/4", s_full, s_count); end
        n_vec++; if (s_in_ready !== 1'b0) begin n_err++;
            $display("FAIL bp in_ready full: got %b want 0", s_in_ready); end
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            n_vec++; if (s_out_valid !== 1'b1 || s_out_data !== want[k]) begin n_err++;
                $display("FAIL bp order k=%0d: got ov=%b od=%h want 1/%h", k, s_out_valid,
                         s_out_data, want[k]); end
        end
        tick();
        n_vec++; if (s_empty !== 1'b1) begin n_err++;
            $display("FAIL bp drained empty: got %b want 1", s_empty); end
    endtask

    task automatic test_full_pushpop();
        for (int k = 0; k < int'(DEPTH); k++) begin
            drive(1'b1, 8'($urandom), 1'b0, 1'b0);
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 8'($urandom), 1'b1, 1'b0);
            tick();
            n_vec++; if (s_in_ready !== 1'b1 || s_out_valid !== 1'b1) begin n_err++;
                $display("FAIL pushpop k=%0d: got ir=%b ov=%b want 1/1", k, s_in_ready,
                         s_out_valid); end
            n_vec++; if (s_count !== CNT_W'(DEPTH) || s_out_data !== s_front) begin n_err++;
                $display("FAIL pushpop k=%0d: got count=%0d od=%h want %0d/%h", k, s_count,
                         s_out_data, DEPTH, s_front); end
        end
        drain();
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'($urandom_range(0, 8'hD0)), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 8'hEE, 1'b0, 1'b1);
        tick();
        n_vec++; if (s_in_ready !== 1'b0 || s_count !== CNT_W'(3)) begin n_err++;
            $display("FAIL flush cycle: got ir=%b count=%0d want 0/3", s_in_ready, s_count); end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        n_vec++; if (s_count !== '0 || s_out_valid !== 1'b0 || s_empty !== 1'b1) begin n_err++;
            $display("FAIL flush after: got count=%0d ov=%b empty=%b want 0/0/1", s_count,
                     s_out_valid, s_empty); end
        for (int k = 0; k < int'(DEPTH); k++) begin
            tick();
            n_vec++; if (s_out_valid !== 1'b0 || s_out_data === 8'hEE) begin n_err++;
                $display("FAIL flush leak k=%0d: got ov=%b od=%h want 0/not EE", k,
                         s_out_valid, s_out_data); end
        end
    endtask

    task automatic test_xscrub();
        drive(1'b1, 8'b1x0z_1010, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (DEPTH - 1) tick();
        tick();
`ifdef DFF_PIPE_XSCRUB_EN
        n_vec++; if (s_out_valid !== 1'b1 || s_out_data !== 8'b1000_1010) begin n_err++;
            $display("FAIL xscrub: got ov=%b od=%b want 1/10001010", s_out_valid, s_out_data);
        end
`else
        n_vec++; if (s_out_valid !== 1'b1 || (s_out_data & 8'hAF) !== 8'h8A) begin n_err++;
            $display("FAIL xpass known bits: got ov=%b od=%b want 1/1?0?1010", s_out_valid,
                     s_out_data); end
`endif
        drain();
    endtask

    task automatic test_random();
        dff_pipe_hs_t hs;
        logic         rdy, fl;
        for (int i = 0; i < 400; i++) begin
            hs.valid = ($urandom_range(0, 3) != 0);
            hs.data  = 8'($urandom);
            rdy      = ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                            : ($urandom_range(0, 3) == 0);
            fl       = ($urandom_range(0, 31) == 0);
            drive(hs.valid, hs.data, rdy, fl);
            tick();
            n_vec++; if (s_count !== CNT_W'(s_size)) begin n_err++;
                $display("FAIL rand count i=%0d: got %0d want %0d", i, s_count, s_size); end
            n_vec++; if (s_empty !== (s_size == 0) || s_full !== (s_size == int'(DEPTH)))
            begin n_err++;
                $display("FAIL rand empty/full i=%0d: got %b/%b size %0d", i, s_empty, s_full,
                         s_size); end
            n_vec++;
            if (s_in_ready !== (!s_flush && (s_size < int'(DEPTH) || s_out_ready))) begin
                n_err++;
                $display("FAIL rand in_ready i=%0d: got %b size %0d fl %b rdy %b", i,
                         s_in_ready, s_size, s_flush, s_out_ready); end
            if (s_size == 0) begin
                n_vec++; if (s_out_valid !== 1'b0) begin n_err++;
                    $display("FAIL rand out_valid on empty i=%0d: got %b want 0", i,
                             s_out_valid); end
            end else if (s_out_valid === 1'b1) begin
                n_vec++; if (s_out_data !== s_front) begin n_err++;
                    $display("FAIL rand order i=%0d: got %h want %h", i, s_out_data, s_front);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_full_pushpop();
        test_flush();
        test_xscrub();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
